// File: rtl/hwregs_pkg.sv
// rtl/hwregs_pkg.sv - register map and shared helpers for the hardware-register window
package hwregs_pkg;

  localparam logic [15:0] HWREG_SEVEN_SEG = 16'h0000;
  localparam logic [15:0] HWREG_LEDS      = 16'h0004;
  localparam logic [15:0] HWREG_SWITCHES  = 16'h0008;
  localparam logic [15:0] HWREG_UART_TX   = 16'h0010;
  localparam logic [15:0] HWREG_UART_STAT = 16'h0014;
  localparam logic [15:0] HWREG_TIMER     = 16'h0020;

  localparam int STAT_EMPTY_BIT    = 0;
  localparam int STAT_FULL_BIT     = 1;
  localparam int STAT_OVERFLOW_BIT = 2;

  // Byte offset matches a register word regardless of addr[1:0].
  function automatic logic addr_hit(input logic [15:0] addr, input logic [15:0] reg_off);
    return (addr & 16'hFFFC) == (reg_off & 16'hFFFC);
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/hwregs_fifo.sv
// rtl/hwregs_fifo.sv - power-of-two synchronous FIFO with occupancy count
module hwregs_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
      else if (!do_push && do_pop) cnt <= cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hwregs.sv
// rtl/hwregs.sv - board I/O register responder for the CPU hardware-register window
module hwregs
  import hwregs_pkg::*;
#(
  parameter int TX_FIFO_DEPTH = 16,
  parameter int LED_WIDTH     = 10,
  parameter int SW_WIDTH      = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_hwregs_req,
  input  logic                 cpu_hwregs_write,
  input  logic [15:0]          cpu_hwregs_addr,
  input  logic [31:0]          cpu_hwregs_wdata,
  input  logic [3:0]           cpu_hwregs_wstrb,
  output logic                 cpu_hwregs_ack,
  output logic [31:0]          cpu_hwregs_rdata,
  output logic [23:0]          seven_seg,
  output logic [LED_WIDTH-1:0] leds,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_valid,
  input  logic                 uart_tx_ready
);
  localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [31:0]         timer;
  logic                overflow;
  logic [CW-1:0]       fifo_count;
  logic [CW-1:0]       free_entries;
  logic                fifo_full;
  logic                fifo_empty;
  logic                rd_req;
  logic                wr_req;
  logic                push;
  logic                pop;
  logic                drop;
  logic [31:0]         read_data;

  assign rd_req        = cpu_hwregs_req && !cpu_hwregs_write;
  assign wr_req        = cpu_hwregs_req &&  cpu_hwregs_write;
  assign pop           = !fifo_empty && uart_tx_ready;
  assign push          = wr_req && addr_hit(cpu_hwregs_addr, HWREG_UART_TX) && cpu_hwregs_wstrb[0];
  assign drop          = push && fifo_full && !pop;
  assign uart_tx_valid = !fifo_empty;
  assign free_entries  = CW'(TX_FIFO_DEPTH) - fifo_count;

  hwregs_fifo #(
    .WIDTH (8),
    .DEPTH (TX_FIFO_DEPTH)
  ) tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (cpu_hwregs_wdata[7:0]),
    .pop       (pop),
    .head      (uart_tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sampled before this cycle's edge, so a UART_TX read sees the pre-pop count.
  always_comb begin
    read_data = '0;
    if (addr_hit(cpu_hwregs_addr, HWREG_SEVEN_SEG))      read_data = 32'(seven_seg);
    else if (addr_hit(cpu_hwregs_addr, HWREG_LEDS))      read_data = 32'(leds);
    else if (addr_hit(cpu_hwregs_addr, HWREG_SWITCHES))  read_data = 32'(sw_sync);
    else if (addr_hit(cpu_hwregs_addr, HWREG_UART_TX))   read_data = 32'(free_entries);
    else if (addr_hit(cpu_hwregs_addr, HWREG_UART_STAT)) begin
      read_data[STAT_EMPTY_BIT]    = fifo_empty;
      read_data[STAT_FULL_BIT]     = fifo_full;
      read_data[STAT_OVERFLOW_BIT] = overflow;
    end
    else if (addr_hit(cpu_hwregs_addr, HWREG_TIMER))     read_data = timer;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_hwregs_ack   <= 1'b0;
      cpu_hwregs_rdata <= '0;
      seven_seg        <= '0;
      leds             <= '0;
      sw_meta          <= '0;
      sw_sync          <= '0;
      timer            <= '0;
      overflow         <= 1'b0;
    end else begin
      cpu_hwregs_ack   <= cpu_hwregs_req;
      cpu_hwregs_rdata <= rd_req ? read_data : '0;
      sw_meta          <= switches;
      sw_sync          <= sw_meta;
      // A write counts as cycle zero, so the next cycle already reads 1.
      if (wr_req && addr_hit(cpu_hwregs_addr, HWREG_TIMER)) timer <= 32'd1;
      else                                                  timer <= timer + 32'd1;
      if (wr_req && addr_hit(cpu_hwregs_addr, HWREG_SEVEN_SEG))
        seven_seg <= 24'(strb_merge(32'(seven_seg), cpu_hwregs_wdata, cpu_hwregs_wstrb));
      if (wr_req && addr_hit(cpu_hwregs_addr, HWREG_LEDS))
        leds <= LED_WIDTH'(strb_merge(32'(leds), cpu_hwregs_wdata, cpu_hwregs_wstrb));
      if (wr_req && addr_hit(cpu_hwregs_addr, HWREG_UART_STAT)) overflow <= 1'b0;
      else if (drop)                                            overflow <= 1'b1;
    end
  end

endmodule

// File: doc/hwregs.md
Name: hwregs

Overview:
- Responder for the CPU data-bus hardware-register window (0xE000_0000–0xE000_FFFF), the target side of the CPU address decoder's cpu_hwregs_req/ack/rdata channel.
- Holds the board I/O registers: seven-segment display, LEDs, synchronised switches, a free-running timer, and a UART transmit FIFO that feeds the UART transmitter.
- Always answers with exactly one registered ack per request, one cycle after the request.
- Drives rdata to zero whenever ack is low, so the decoder can OR-merge it with the dcache read data.

Parameters:
- TX_FIFO_DEPTH, 16, UART TX FIFO entries; must be a power of two, ≥2.
- LED_WIDTH, 10, number of LED outputs.
- SW_WIDTH, 10, number of switch inputs.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_hwregs_req  in  1  one-cycle request strobe from the address decoder
- cpu_hwregs_write  in  1  1 = write, 0 = read; valid with req
- cpu_hwregs_addr  in  16  byte offset in the window; bits [1:0] ignored
- cpu_hwregs_wdata  in  32  write data
- cpu_hwregs_wstrb  in  4  byte write enables
- cpu_hwregs_ack  out  1  response strobe, exactly one per req
- cpu_hwregs_rdata  out  32  read data; 0 when ack low
- seven_seg  out  24  six 4-bit hex digits
- leds  out  LED_WIDTH  LED drive
- switches  in  SW_WIDTH  asynchronous board switches
- uart_tx_data  out  8  byte to the UART transmitter
- uart_tx_valid  out  1  FIFO not empty
- uart_tx_ready  in  1  transmitter accepts the byte (pop when valid && ready)

Behaviour:
- Reset (async assert): ack=0, rdata=0, seven_seg=0, leds=0, timer=0, FIFO empty, overflow=0, switch synchronisers=0, uart_tx_valid=0.
- Latency: for req in cycle N, ack=1 in cycle N+1 for exactly one cycle; rdata is valid in N+1.
  - Read data is captured in cycle N (registered).
  - Write side effects are applied at the clock edge ending cycle N.
- Back-to-back req on consecutive cycles is legal; each gets its own ack.
- Register map (word offsets):
  - 0x00 SEVEN_SEG, RW, bits[23:0]; byte-strobed (wstrb[3] ignored).
  - 0x04 LEDS, RW, bits[LED_WIDTH-1:0]; byte-strobed.
  - 0x08 SWITCHES, RO; value after a 2-flop synchroniser.
  - 0x10 UART_TX:
    - Write with wstrb[0]=1 pushes wdata[7:0].
    - Read returns the free-entry count, zero-extended.
  - 0x14 UART_STAT, bit0 = FIFO empty, bit1 = FIFO full, bit2 = sticky overflow.
    - Any write clears overflow.
  - 0x20 TIMER, 32-bit cycle counter, increments every cycle and wraps 0xFFFF_FFFF→0.
    - Any write loads 0; the counter reads 1 in the following cycle.
- Unmapped offsets: reads return 0, writes are ignored; both still ack.
- Writes to RO registers are ignored.
- Reads have no side effects.
- FIFO:
  - Pop when uart_tx_valid && uart_tx_ready.
  - Push when full with no pop in the same cycle: the byte is dropped, overflow is set, and the request is still acked.
  - Push and pop in the same cycle while full: both are accepted and the count is unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect, because valid was 0.
  - uart_tx_data = head entry; it is undefined-but-stable while empty.
- Read of UART_TX in the same cycle as a pop returns the count before the pop.
- Reset asserted mid-transaction: any pending ack is dropped and no ack follows.

Decomposition:
- Package hwregs_pkg: register offset localparams (HWREG_SEVEN_SEG, HWREG_LEDS, HWREG_SWITCHES, HWREG_UART_TX, HWREG_UART_STAT, HWREG_TIMER) and the UART_STAT bit positions; shared with software headers and the bench.
- Sub-module hwregs_fifo (parameterised width/depth, push/pop/full/empty/count) instantiated once for TX.

Test Plan:
- Write 0x0012_3456 to 0x00 with wstrb=0xF, then read 0x00 → ack exactly one cycle after each req; read rdata=0x0012_3456; seven_seg=0x123456; rdata=0 in all non-ack cycles.
- Write 0x3FF to 0x04 with wstrb=0x1 → leds=0x0FF; then wstrb=0x2 with data 0x300 → leds=0x3FF.
- Hold uart_tx_ready=0 and push 17 bytes 0x41..0x51 (depth 16) → read 0x10 returns 0; 0x14 reads 0x6; raise ready → bytes 0x41..0x50 pop in order, 0x51 absent; 0x14 then reads 0x5 (empty|overflow).
- Write 0 to TIMER, then read it 10 cycles later → value equals the measured cycle distance; preload-style check shows wrap from 0xFFFF_FFFF to 0.
- Back-to-back reads of 0x08 (switches=0x2AA, stable ≥3 cycles) and unmapped 0x40 → two consecutive acks, rdata 0x2AA then 0.
- Assert reset in the cycle after a req → ack stays 0, all outputs return to reset values immediately.
